// File: rtl/if_prefetch_if.sv
// if_prefetch_if
// Bundles every non-clock signal of the instruction-fetch front end.
//   imem_addr/imem_ce/imem_rdata : synchronous instruction RAM port (1-cycle read latency)
//   redirect/redirect_pc         : flush-and-restart request from execute
//   out_valid/out_ready          : decode handshake
//   out_pc/out_inst              : head entry of the prefetch FIFO
//   level                        : FIFO occupancy
// master = the prefetch unit, slave = the surrounding pipeline/memory.
interface if_prefetch_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic          imem_ce;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [LW-1:0] level;

  modport master (
    output imem_addr, imem_ce,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc, out_inst, level
  );

  modport slave (
    input  imem_addr, imem_ce,
    output imem_rdata,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_inst, level
  );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch
// Instruction-fetch front end: a PC generator feeding a DEPTH-entry FIFO of
// {pc, inst} pairs. Reads go to a synchronous RAM whose data returns one
// cycle after the request; decode drains the FIFO through a valid/ready
// handshake, and a redirect flushes both the FIFO and the returning read.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous, active-high reset (overrides redirect)
//   fetch_if : if_prefetch_if.master carrying imem, redirect and decode signals
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  if_prefetch_if.master fetch_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_inst_q [DEPTH];

  logic          out_valid;
  logic          pop;
  logic          fill;
  logic          issue_ok;
  logic [OW-1:0] occupancy;
  logic [31:0]   redirect_tgt;
  logic          imem_ce;
  logic [31:0]   imem_addr;

  assign out_valid    = (count_q != '0);
  assign pop          = out_valid & fetch_if.out_ready & ~fetch_if.redirect;
  assign fill         = inflight_q & ~fetch_if.redirect & ~rst;
  assign redirect_tgt = fetch_if.redirect_pc & 32'hFFFF_FFFC;

  // Slots already committed (queued + in flight) minus the one leaving this
  // cycle; issuing only while this stays below DEPTH means the returning
  // read always finds a free entry, so no overflow check is needed on fill.
  assign occupancy = OW'(count_q) + OW'(inflight_q) - OW'(pop);
  assign issue_ok  = (occupancy < OW'(DEPTH));

  // Next-state and RAM request. Reset is folded in here so the registers
  // below stay a plain copy; redirect wins over normal issue/fill/pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    imem_ce       = 1'b0;
    imem_addr     = fetch_pc_q;

    if (rst) begin
      fetch_pc_d    = RESET_PC;
      inflight_d    = 1'b0;
      inflight_pc_d = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      imem_addr     = RESET_PC;
    end else if (fetch_if.redirect) begin
      imem_ce       = 1'b1;
      imem_addr     = redirect_tgt;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_tgt;
      fetch_pc_d    = redirect_tgt + 32'd4;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (issue_ok) begin
        imem_ce       = 1'b1;
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end
      if (fill) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(fill) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q    <= fetch_pc_d;
    inflight_q    <= inflight_d;
    inflight_pc_q <= inflight_pc_d;
    wr_ptr_q      <= wr_ptr_d;
    rd_ptr_q      <= rd_ptr_d;
    count_q       <= count_d;
  end

  // FIFO storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (fill) begin
      mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
      mem_inst_q[wr_ptr_q] <= fetch_if.imem_rdata;
    end
  end

  assign fetch_if.imem_ce   = imem_ce;
  assign fetch_if.imem_addr = imem_addr;
  assign fetch_if.out_valid = out_valid;
  assign fetch_if.out_pc    = out_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
  assign fetch_if.out_inst  = out_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
  assign fetch_if.level     = count_q;

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch
// Drives if_prefetch with directed scenarios followed by random traffic.
// A queue-based reference model of the fetch stream is checked against the
// DUT outputs on every falling edge; directed scenarios add literal checks.
module tb_if_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  if_prefetch_if #(.DEPTH(DEPTH)) bus ();

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Synchronous RAM: the request is captured mid-cycle so it reflects the
  // settled pre-edge request, then answered at the following rising edge.
  logic        memCe   = 1'b0;
  logic [31:0] memAddr = 32'h0;
  always @(negedge clk) begin
    memCe   <= bus.imem_ce;
    memAddr <= bus.imem_addr;
  end
  always @(posedge clk) begin
    if (memCe) bus.imem_rdata <= instOf(memAddr);
  end

  // Reference model: a queue of PCs that have come back from memory, plus
  // at most one pending request.
  logic [31:0] mq[$];
  bit          mPend       = 1'b0;
  logic [31:0] mPendPc     = 32'h0;
  logic [31:0] mFetch      = 32'h0;
  bit          modelReady  = 1'b0;

  always @(posedge clk) begin : modelStep
    bit          popNow;
    bit          issueNow;
    logic [31:0] tgt;
    if (rst) begin
      mq.delete();
      mPend      <= 1'b0;
      mFetch     <= RESET_PC;
      modelReady <= 1'b1;
    end else if (bus.redirect) begin
      tgt = {bus.redirect_pc[31:2], 2'b00};
      mq.delete();
      mPend   <= 1'b1;
      mPendPc <= tgt;
      mFetch  <= tgt + 32'd4;
    end else begin
      popNow   = (mq.size() != 0) && bus.out_ready;
      issueNow = (mq.size() + int'(mPend) - int'(popNow)) < int'(DEPTH);
      if (popNow) void'(mq.pop_front());
      if (mPend) mq.push_back(mPendPc);
      if (issueNow) begin
        mPendPc <= mFetch;
        mFetch  <= mFetch + 32'd4;
        mPend   <= 1'b1;
      end else begin
        mPend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compareStep
    int          size;
    bit          popNow;
    logic [31:0] expPc;
    logic        expCe;
    logic [31:0] expAddr;
    if (modelReady) begin
      size   = mq.size();
      expPc  = (size != 0) ? mq[0] : 32'h0;
      popNow = (size != 0) && bus.out_ready && !bus.redirect;
      if (rst) begin
        expCe   = 1'b0;
        expAddr = RESET_PC;
      end else if (bus.redirect) begin
        expCe   = 1'b1;
        expAddr = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        expCe   = (size + int'(mPend) - int'(popNow)) < int'(DEPTH);
        expAddr = mFetch;
      end
      checkOutput("model out_valid", 32'(bus.out_valid), 32'(size != 0));
      checkOutput("model out_pc", bus.out_pc, expPc);
      checkOutput("model out_inst", bus.out_inst, (size != 0) ? instOf(expPc) : 32'h0);
      checkOutput("model level", 32'(bus.level), 32'(size));
      checkOutput("model imem_ce", 32'(bus.imem_ce), 32'(expCe));
      checkOutput("model imem_addr", bus.imem_addr, expAddr);
    end
  end

  // One cycle of stimulus: change inputs just after the rising edge, then
  // return at the falling edge so the caller can inspect settled outputs.
  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc,
                               input logic rdy);
    @(posedge clk);
    #1;
    rst             = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;

    // Reset values
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst imem_ce", 32'(bus.imem_ce), 32'h0);
    checkOutput("rst imem_addr", bus.imem_addr, RESET_PC);
    applyStimulus(1, 0, 0, 1);
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst level", 32'(bus.level), 32'h0);

    // Reset start: first request in cycle 0, data visible in cycle 2
    applyStimulus(0, 0, 0, 1);
    checkOutput("start c0 ce", 32'(bus.imem_ce), 32'h1);
    checkOutput("start c0 addr", bus.imem_addr, 32'h0);
    checkOutput("start c0 valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("start c1 addr", bus.imem_addr, 32'h4);
    checkOutput("start c1 valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("start c2 valid", 32'(bus.out_valid), 32'h1);
    checkOutput("start c2 pc", bus.out_pc, 32'h0);
    checkOutput("start c2 inst", bus.out_inst, 32'h1357_9BDF);
    for (int k = 3; k < 8; k++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("start stream pc", bus.out_pc, 32'(4 * (k - 2)));
      checkOutput("start stream ce", 32'(bus.imem_ce), 32'h1);
    end

    // Backpressure: fill to DEPTH, then drain without gaps
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0);
    checkOutput("bp level", 32'(bus.level), 32'h4);
    checkOutput("bp ce", 32'(bus.imem_ce), 32'h0);
    checkOutput("bp head", bus.out_pc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("bp drain valid", 32'(bus.out_valid), 32'h1);
      checkOutput("bp drain pc", bus.out_pc, 32'(4 * k));
    end

    // Redirect while streaming drops the in-flight read
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h100, 1);
    checkOutput("redir ce", 32'(bus.imem_ce), 32'h1);
    checkOutput("redir addr", bus.imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir t1 valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir t2 pc", bus.out_pc, 32'h100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir t3 pc", bus.out_pc, 32'h104);

    // Misaligned redirect with out_ready high and level 3
    applyStimulus(0, 1, 32'h300, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h203, 1);
    checkOutput("misal level", 32'(bus.level), 32'h3);
    checkOutput("misal addr", bus.imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0);
    checkOutput("misal t1 level", 32'(bus.level), 32'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("misal t2 pc", bus.out_pc, 32'h200);

    // Address wrap
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap pc0", bus.out_pc, 32'hFFFF_FFF8);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap pc1", bus.out_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap pc2", bus.out_pc, 32'h0);

    // Reset mid-stream with level 2 and a read in flight
    applyStimulus(0, 1, 32'h500, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
    checkOutput("midrst pre level", 32'(bus.level), 32'h2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("midrst ce", 32'(bus.imem_ce), 32'h0);
    checkOutput("midrst addr", bus.imem_addr, RESET_PC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst level", 32'(bus.level), 32'h0);
    checkOutput("midrst valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst restart addr", bus.imem_addr, RESET_PC);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst restart pc", bus.out_pc, RESET_PC);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic        r;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 29) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
      rdy = ($urandom_range(0, 99) < 65);
      applyStimulus(r, rd, rpc, rdy);
    end

    applyStimulus(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch front end for the RV32I/Zicsr pipeline. It replaces the single fetch PC register with a PC generator and a configurable-depth prefetch FIFO of {pc, inst} pairs. Instruction memory is a synchronous single-read-port RAM with 1-cycle read latency. Decode consumes entries through a valid/ready handshake, and execute redirects fetch on a branch mispredict, trap or mret, flushing all queued and in-flight fetches.

## Interface

- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `imem_addr` output, 32 bits: word-aligned fetch address.
- `imem_ce` output, 1 bit: read enable. A read issued at cycle t returns `imem_rdata` at cycle t+1.
- `imem_rdata` input, 32 bits: instruction word. Valid the cycle after `imem_ce`.
- `redirect` input, 1 bit: flush and restart fetch at `redirect_pc`.
- `redirect_pc` input, 32 bits: new fetch target. Bits [1:0] are ignored and forced to 0.
- `out_valid` output, 1 bit: FIFO head holds a valid instruction.
- `out_ready` input, 1 bit: decode accepts the head this cycle.
- `out_pc` output, 32 bits: PC of the head entry.
- `out_inst` output, 32 bits: instruction of the head entry.
- `level` output, $clog2(DEPTH)+1 bits: FIFO occupancy.

## Operation

**State**
- `fetch_pc`: next address to request.
- `inflight`: 1 bit, meaning a read was issued last cycle.
- `inflight_pc`: PC of that read.
- FIFO: `DEPTH` entries of {pc, inst}, with wr_ptr/rd_ptr and `count`.

**Pop**
- `pop = out_valid & out_ready & ~redirect`.

**Issue (normal cycle, no redirect)**
- Issue when `count + inflight - pop < DEPTH`. This gives one instruction per cycle steady-state throughput for any DEPTH ≥ 2.
- On issue: `imem_ce=1`, `imem_addr=fetch_pc`, `fetch_pc <= fetch_pc+4` (mod 2^32 wrap), `inflight <= 1`, `inflight_pc <= fetch_pc`.
- No issue: `imem_ce=0`, `imem_addr=fetch_pc`, `inflight <= 0`.

**Fill**
- If `inflight & ~redirect`, write {`inflight_pc`, `imem_rdata`} at wr_ptr.
- The issue rule guarantees the FIFO can never overflow.

**Count**
- `count` updates by (+fill − pop). Simultaneous fill and pop leaves `count` unchanged.

**Redirect (priority over all else)**
- Clear the FIFO: pointers and `count` go to 0.
- Discard the read currently returning: no fill.
- Issue immediately: `imem_ce=1`, `imem_addr={redirect_pc[31:2],2'b00}`, `inflight <= 1`, `inflight_pc <=` aligned target, `fetch_pc <=` aligned target + 4.
- Any `out_ready` in the same cycle is ignored.

**Outputs**
- `out_valid = (count != 0)`.
- `out_pc` and `out_inst` show the head entry when `out_valid`, and are driven 0 otherwise.
- `level = count`.

**Reset**
- `fetch_pc <= RESET_PC`, `inflight <= 0`, FIFO cleared.
- While `rst=1`: `imem_ce=0`, `imem_addr=RESET_PC`.
- `rst` overrides `redirect`.

## Timing

**Reset values**
- `imem_ce=0`, `imem_addr=RESET_PC`.
- `out_valid=0`, `out_pc=0`, `out_inst=0`, `level=0`.

**Latency**
- First request is issued in the first cycle with `rst=0` (cycle 0). `out_valid` rises at cycle 2 with `out_pc=RESET_PC`.
- Redirect at cycle t: the target is requested in cycle t, filled at the t+1 edge, and `out_valid` is high in cycle t+2 with `out_pc=` target. There is no FIFO bypass.

**Handshake**
- The head is consumed on any edge where `out_valid & out_ready & ~redirect`.
- The head is stable while `out_valid & ~out_ready` and no redirect occurs.

**Boundary cases**
- Full FIFO with `out_ready=0`: issue stops. `imem_ce=0` once `count + inflight = DEPTH`.
- Full FIFO with a pop: issue continues in the same cycle.
- Empty FIFO with `out_ready=1`: no pop, `count` stays 0.
- `fetch_pc` wraps from 32'hFFFF_FFFC to 0.
- Reset asserted mid-stream: everything is discarded at that edge. The next cycle with `rst=0` restarts at `RESET_PC`.

## Test plan

- **Reset start:** release reset with `RESET_PC`=0 and `out_ready=1`, memory returning inst=addr. Expect `out_valid` at cycle 2 with pc=0, then pc=4, 8, 12… on consecutive cycles, and `imem_ce` held at 1.
- **Backpressure:** DEPTH=4, `out_ready=0`. Expect `level` to reach 4, `imem_ce` to drop, and the head to stay pc=0. Then set `out_ready=1` and expect pcs 0, 4, 8, 12, 16 with no gaps and no duplicates.
- **Redirect with in-flight drop:** while streaming, `redirect=1` with `redirect_pc`=0x100 at cycle t. Expect `imem_addr`=0x100 at t, no stale PC appearing at t+1, and `out_pc`=0x100 at t+2 followed by 0x104.
- **Misaligned redirect with simultaneous ready:** `redirect_pc`=0x203 with `out_ready=1` and `level`=3. Expect no pop, `level`=0 at t+1, and head pc=0x200.
- **Wrap:** redirect to 0xFFFF_FFF8. Expect the output PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- **Reset mid-stream:** assert `rst` for 1 cycle while `level`=2 and a read is in flight. Expect `level`=0 and `out_valid`=0 next cycle, and `imem_ce`=0 during reset.
